// File: rtl/gelato_pkg.sv
// ============================================================================
// Module   : gelato_pkg
// Purpose  : shared gelato types for the warp instruction buffer
// Revision : 1.0
// ============================================================================
`default_nettype none

package gelato_pkg;

    localparam int GELATO_NUM_WARPS = 4;
    localparam int GELATO_WARP_ID_W = $clog2(GELATO_NUM_WARPS);

    typedef logic [GELATO_WARP_ID_W-1:0] warp_id_t;
    typedef logic [31:0]                 addr_t;
    typedef logic [31:0]                 inst_t;

    typedef struct packed {
        addr_t pc;
        inst_t inst;
    } ibuf_entry_t;

endpackage

`default_nettype wire

// File: rtl/gelato_rr_arbiter.sv
// ============================================================================
// Module   : gelato_rr_arbiter
// Purpose  : round-robin grant that holds a stalled grant until accepted
// Revision : 1.0
// ============================================================================
`default_nettype none

module gelato_rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    input  logic                 flush_valid,
    input  logic [$clog2(N)-1:0] flush_idx,
    output logic                 grant_valid,
    output logic [N-1:0]         grant_oh,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int c_iw = $clog2(N);

    logic [c_iw-1:0] r_last;
    logic            r_lock;
    logic [c_iw-1:0] r_lock_idx;

    logic            w_rr_found;
    logic [c_iw-1:0] w_rr_idx;
    logic [c_iw-1:0] w_cand;

    // Search starts one past the last popped warp; i==N wraps back to r_last.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = r_last;
        w_cand     = r_last;
        for (int i = 1; i <= N; i++) begin
            w_cand = r_last + c_iw'(i);
            if (!w_rr_found && req[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (r_lock) begin
            grant_idx   = r_lock_idx;
            grant_valid = en && req[r_lock_idx];
        end else begin
            grant_idx   = w_rr_idx;
            grant_valid = en && w_rr_found;
        end
        grant_oh[grant_idx] = grant_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= c_iw'(N - 1);
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (en) begin
            if (flush_valid && r_lock && (flush_idx == r_lock_idx)) begin
                r_lock <= 1'b0;
            end else if (grant_valid && advance) begin
                r_last <= grant_idx;
                r_lock <= 1'b0;
            end else if (grant_valid) begin
                r_lock     <= 1'b1;
                r_lock_idx <= grant_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gelato_ibuffer.sv
// ============================================================================
// Module   : gelato_ibuffer
// Purpose  : per-warp instruction FIFOs between fetch and decode
// Revision : 1.0
// ============================================================================
`default_nettype none

module gelato_ibuffer
    import gelato_pkg::*;
#(
    parameter int NUM_WARPS = GELATO_NUM_WARPS,
    parameter int DEPTH     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rdy,
    input  logic                         fetch_valid,
    output logic                         fetch_ready,
    input  logic [$clog2(NUM_WARPS)-1:0] fetch_warp_id,
    input  logic [31:0]                  fetch_pc,
    input  logic [31:0]                  fetch_inst,
    output logic [NUM_WARPS-1:0]         warp_full,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [$clog2(NUM_WARPS)-1:0] issue_warp_id,
    output logic [31:0]                  issue_pc,
    output logic [31:0]                  issue_inst,
    input  logic                         flush_valid,
    input  logic [$clog2(NUM_WARPS)-1:0] flush_warp_id
);

    localparam int               c_wid_w = $clog2(NUM_WARPS);
    localparam int               c_ptr_w = $clog2(DEPTH);
    localparam int               c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [NUM_WARPS-1:0] w_req;
    logic [NUM_WARPS-1:0] w_grant_oh;
    logic [c_wid_w-1:0]   w_grant_idx;
    logic                 w_grant_valid;
    logic                 w_push;
    logic                 w_pop;
    ibuf_entry_t          w_head [NUM_WARPS];
    ibuf_entry_t          w_sel;
    ibuf_entry_t          w_fetch_entry;

    // No bypass: readiness depends only on stored occupancy and the flush.
    assign fetch_ready = rdy && !warp_full[fetch_warp_id]
                         && !(flush_valid && (flush_warp_id == fetch_warp_id));
    assign w_push        = fetch_valid && fetch_ready;
    assign w_pop         = w_grant_valid && issue_ready;
    assign w_fetch_entry = '{pc: fetch_pc, inst: fetch_inst};

    genvar gw;
    generate
        for (gw = 0; gw < NUM_WARPS; gw++) begin : g_warp
            ibuf_entry_t        r_mem [DEPTH];
            logic [c_ptr_w-1:0] r_rd_ptr;
            logic [c_ptr_w-1:0] r_wr_ptr;
            logic [c_cnt_w-1:0] r_count;
            logic               w_flush_hit;
            logic               w_push_w;
            logic               w_pop_w;

            assign w_flush_hit   = flush_valid && (flush_warp_id == c_wid_w'(gw));
            assign w_push_w      = w_push && (fetch_warp_id == c_wid_w'(gw));
            assign w_pop_w       = w_pop && w_grant_oh[gw];
            assign warp_full[gw] = (r_count == c_depth);
            assign w_req[gw]     = (r_count != '0) && !w_flush_hit;
            assign w_head[gw]    = r_mem[r_rd_ptr];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_count  <= '0;
                end else if (rdy && w_flush_hit) begin
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push_w) r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_pop_w)  r_rd_ptr <= r_rd_ptr + 1'b1;
                    if (w_push_w && !w_pop_w)      r_count <= r_count + 1'b1;
                    else if (w_pop_w && !w_push_w) r_count <= r_count - 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (w_push_w) r_mem[r_wr_ptr] <= w_fetch_entry;
            end
        end
    endgenerate

    gelato_rr_arbiter #(
        .N (NUM_WARPS)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (rdy),
        .req         (w_req),
        .advance     (issue_ready),
        .flush_valid (flush_valid),
        .flush_idx   (flush_warp_id),
        .grant_valid (w_grant_valid),
        .grant_oh    (w_grant_oh),
        .grant_idx   (w_grant_idx)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (w_grant_oh[i]) w_sel = w_head[i];
        end
    end

    assign issue_valid   = w_grant_valid;
    assign issue_warp_id = w_grant_idx;
    assign issue_pc      = w_sel.pc;
    assign issue_inst    = w_sel.inst;

endmodule

`default_nettype wire

// File: tb/tb_gelato_ibuffer.sv
// ============================================================================
// Module   : tb_gelato_ibuffer
// Purpose  : queue-model bench for gelato_ibuffer, directed plus random
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gelato_ibuffer;

    localparam int NW = 4;
    localparam int DP = 2;

    logic          clk;
    logic          rst_n;
    logic          rdy;
    logic          fetch_valid;
    logic          fetch_ready;
    logic [1:0]    fetch_warp_id;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_inst;
    logic [NW-1:0] warp_full;
    logic          issue_valid;
    logic          issue_ready;
    logic [1:0]    issue_warp_id;
    logic [31:0]   issue_pc;
    logic [31:0]   issue_inst;
    logic          flush_valid;
    logic [1:0]    flush_warp_id;

    gelato_ibuffer #(
        .NUM_WARPS (NW),
        .DEPTH     (DP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdy           (rdy),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .fetch_warp_id (fetch_warp_id),
        .fetch_pc      (fetch_pc),
        .fetch_inst    (fetch_inst),
        .warp_full     (warp_full),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_warp_id (issue_warp_id),
        .issue_pc      (issue_pc),
        .issue_inst    (issue_inst),
        .flush_valid   (flush_valid),
        .flush_warp_id (flush_warp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one queue of {pc,inst} per warp plus arbitration state.
    logic [63:0] mq [NW][$];
    int          m_last;
    bit          m_lock;
    int          m_lock_w;
    bit          e_push, e_pop, e_valid;
    int          e_sel;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit eligible(input int w);
        return (mq[w].size() > 0) && !(flush_valid && int'(flush_warp_id) == w);
    endfunction

    task automatic model_clear();
        for (int w = 0; w < NW; w++) mq[w].delete();
        m_last = NW - 1;
        m_lock = 1'b0;
        m_lock_w = 0;
    endtask

    task automatic compare();
        bit            e_fr;
        bit            found;
        logic [NW-1:0] e_full;
        n_vec++;
        e_fr = rdy && (mq[int'(fetch_warp_id)].size() < DP)
               && !(flush_valid && flush_warp_id == fetch_warp_id);
        for (int w = 0; w < NW; w++) e_full[w] = (mq[w].size() == DP);
        found = 1'b0;
        e_sel = 0;
        if (m_lock) begin
            e_sel = m_lock_w;
            found = eligible(m_lock_w);
        end else begin
            for (int k = 1; k <= NW; k++) begin
                int c;
                c = (m_last + k) % NW;
                if (!found && eligible(c)) begin
                    found = 1'b1;
                    e_sel = c;
                end
            end
        end
        e_valid = rdy && found;
        chk("fetch_ready", fetch_ready, e_fr);
        chk("warp_full", warp_full, e_full);
        chk("issue_valid", issue_valid, e_valid);
        if (e_valid) begin
            chk("issue_warp_id", issue_warp_id, e_sel);
            chk("issue_pc", issue_pc, mq[e_sel][0][63:32]);
            chk("issue_inst", issue_inst, mq[e_sel][0][31:0]);
        end
        e_push = fetch_valid && e_fr;
        e_pop  = e_valid && issue_ready;
    endtask

    task automatic model_update();
        if (rdy) begin
            if (flush_valid) begin
                mq[int'(flush_warp_id)].delete();
                if (m_lock && m_lock_w == int'(flush_warp_id)) m_lock = 1'b0;
            end
            if (e_pop) begin
                void'(mq[e_sel].pop_front());
                m_last = e_sel;
                m_lock = 1'b0;
            end else if (e_valid) begin
                m_lock   = 1'b1;
                m_lock_w = e_sel;
            end
            if (e_push) mq[int'(fetch_warp_id)].push_back({fetch_pc, fetch_inst});
        end
    endtask

    task automatic drive(input bit fv, input int fw, input logic [31:0] pc,
                         input logic [31:0] inst, input bit ir, input bit fl,
                         input int flw, input bit r);
        fetch_valid   = fv;
        fetch_warp_id = 2'(fw);
        fetch_pc      = pc;
        fetch_inst    = inst;
        issue_ready   = ir;
        flush_valid   = fl;
        flush_warp_id = 2'(flw);
        rdy           = r;
        #1;
        compare();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input bit ir);
        drive(1'b0, 0, 32'h0, 32'h0, ir, 1'b0, 0, 1'b1);
    endtask

    // Reset lands mid-cycle so in-flight handshakes are discarded.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_issue_valid", issue_valid, 1'b0);
        chk("rst_warp_full", warp_full, 4'b0000);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        fetch_valid = 1'b0;
        flush_valid = 1'b0;
        issue_ready = 1'b0;
        rdy         = 1'b1;
        rst_n       = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_valid = 1'b0; fetch_warp_id = '0; fetch_pc = '0; fetch_inst = '0;
        issue_ready = 1'b0; flush_valid = 1'b0; flush_warp_id = '0; rdy = 1'b1;
        model_clear();
        @(negedge clk);
        do_reset();

        // Single push, one-cycle latency, then drain.
        drive(1'b1, 2, 32'h100, 32'h13, 1'b0, 1'b0, 0, 1'b1);
        chk("lit_fr_first", fetch_ready, 1'b1);
        chk("lit_iv_latency", issue_valid, 1'b0);
        tick();
        idle(1'b1);
        chk("lit_iv_w2", issue_valid, 1'b1);
        chk("lit_id_w2", issue_warp_id, 2'd2);
        chk("lit_pc_w2", issue_pc, 32'h100);
        chk("lit_inst_w2", issue_inst, 32'h13);
        tick();
        idle(1'b1);
        chk("lit_iv_empty", issue_valid, 1'b0);
        tick();

        // Fill warp 1, then flush it while it is presented.
        drive(1'b1, 1, 32'h200, 32'h1, 1'b0, 1'b0, 0, 1'b1); tick();
        drive(1'b1, 1, 32'h204, 32'h2, 1'b0, 1'b0, 0, 1'b1); tick();
        drive(1'b0, 1, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b1);
        chk("lit_full_w1", warp_full, 4'b0010);
        chk("lit_fr_w1", fetch_ready, 1'b0);
        chk("lit_id_full", issue_warp_id, 2'd1);
        drive(1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b1);
        chk("lit_fr_w0", fetch_ready, 1'b1);
        drive(1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1, 1, 1'b1);
        chk("lit_iv_flush", issue_valid, 1'b0);
        tick();
        idle(1'b0);
        chk("lit_full_after_flush", warp_full, 4'b0000);
        chk("lit_iv_after_flush", issue_valid, 1'b0);
        tick();

        // Round-robin order over warps 0, 1, 3.
        do_reset();
        drive(1'b1, 0, 32'h10, 32'hA0, 1'b0, 1'b0, 0, 1'b1); tick();
        drive(1'b1, 1, 32'h20, 32'hA1, 1'b0, 1'b0, 0, 1'b1); tick();
        drive(1'b1, 3, 32'h30, 32'hA3, 1'b0, 1'b0, 0, 1'b1); tick();
        idle(1'b1); chk("lit_rr0", issue_warp_id, 2'd0); tick();
        idle(1'b1); chk("lit_rr1", issue_warp_id, 2'd1); tick();
        idle(1'b1); chk("lit_rr3", issue_warp_id, 2'd3); tick();
        idle(1'b1); chk("lit_rr_done", issue_valid, 1'b0); tick();

        // Stalled warp 1 holds even though warp 0 would win the search.
        do_reset();
        drive(1'b1, 1, 32'h40, 32'hB1, 1'b0, 1'b0, 0, 1'b1); tick();
        drive(1'b1, 0, 32'h50, 32'hB0, 1'b0, 1'b0, 0, 1'b1);
        chk("lit_lock_a", issue_warp_id, 2'd1);
        tick();
        idle(1'b0); chk("lit_lock_b", issue_warp_id, 2'd1); tick();
        idle(1'b1); chk("lit_lock_pc", issue_pc, 32'h40); tick();
        idle(1'b1); chk("lit_after_lock", issue_warp_id, 2'd0); tick();

        // rdy low freezes everything.
        do_reset();
        drive(1'b1, 2, 32'h60, 32'hC2, 1'b0, 1'b0, 0, 1'b1); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 0, 32'h70, 32'hC0, 1'b1, 1'b0, 0, 1'b0);
            chk("lit_rdy_fr", fetch_ready, 1'b0);
            chk("lit_rdy_iv", issue_valid, 1'b0);
            tick();
        end
        idle(1'b0);
        chk("lit_rdy_back", issue_warp_id, 2'd2);
        chk("lit_rdy_pc", issue_pc, 32'h60);
        tick();

        // Randomized traffic with a mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            bit ir;
            if (i == 1500) begin
                do_reset();
                drive(1'b1, 3, 32'hDEAD0000, 32'h1234, 1'b0, 1'b0, 0, 1'b1);
                chk("lit_push_after_reset", fetch_ready, 1'b1);
                tick();
            end
            ir = ((i % 400) < 200) ? ($urandom % 4 == 0) : ($urandom % 3 != 0);
            drive($urandom % 4 != 0, int'($urandom % NW), $urandom, $urandom, ir,
                  $urandom % 12 == 0, int'($urandom % NW), $urandom % 8 != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
